scan_test_ctrl: RTL

- On-chip scan test controller that sits directly upstream and downstream of the scan-inserted s9234 core's single scan chain.
- Drives the chain's SE and scan_in from a pseudo-random pattern generator (PRPG).
- Sequences the shift/capture cycles for a programmable number of patterns.
- Compacts the chain's scan_out into a serial-input signature register (SISR) for pass/fail readout.

---
 rtl/scan_test_ctrl_if.sv | 39 +++
 rtl/scan_test_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl_if.sv
// Control/observe bundle between a host and scan_test_ctrl.
// With SCAN_CMP_EN defined it also carries the expected signature and the pass flag.
interface scan_test_ctrl_if #(
  parameter int PAT_W  = 16,
  parameter int LFSR_W = 16
);
  logic              i_start;
  logic              i_abort;
  logic [PAT_W-1:0]  i_num_patterns;
  logic [LFSR_W-1:0] i_seed;
  logic              i_scan_out;
  logic              o_se;
  logic              o_scan_in;
  logic              o_busy;
  logic              o_done;
  logic [LFSR_W-1:0] o_signature;
`ifdef SCAN_CMP_EN
  logic [LFSR_W-1:0] i_expected_sig;
  logic              o_pass;
`endif

  modport slave (
`ifdef SCAN_CMP_EN
    input  i_expected_sig,
    output o_pass,
`endif
    input  i_start, i_abort, i_num_patterns, i_seed, i_scan_out,
    output o_se, o_scan_in, o_busy, o_done, o_signature
  );

  modport master (
`ifdef SCAN_CMP_EN
    output i_expected_sig,
    input  o_pass,
`endif
    output i_start, i_abort, i_num_patterns, i_seed, i_scan_out,
    input  o_se, o_scan_in, o_busy, o_done, o_signature
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan test controller: PRPG drives the chain, SISR compacts its output over a pattern run.
// Optional signature comparator enabled by defining SCAN_CMP_EN.
module scan_test_ctrl #(
  parameter int                CHAIN_LEN = 211,
  parameter int                PAT_W     = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] POLY      = 16'h1021
) (
  input logic             clk,
  input logic             rst_n,
  scan_test_ctrl_if.slave bus
);
  localparam int             CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v, input logic din);
    lfsr_step = {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? POLY : {LFSR_W{1'b0}})
              ^ {{(LFSR_W-1){1'b0}}, din};
  endfunction

  state_t            r_state, w_state_nxt;
  logic [LFSR_W-1:0] r_prpg, w_prpg_nxt;
  logic [LFSR_W-1:0] r_sisr, w_sisr_nxt;
  logic [PAT_W-1:0]  r_pat_cnt, w_pat_nxt;
  logic [CNT_W-1:0]  r_shift_cnt, w_cnt_nxt;
  logic              r_first_load, w_first_nxt;
  logic              r_se, r_scan_in, r_busy, r_done;
  logic              w_busy, w_busy_nxt;
`ifdef SCAN_CMP_EN
  logic [LFSR_W-1:0] r_exp_sig, w_exp_nxt;
  logic              r_pass;
`endif

  // Next-state, pattern/shift counters, PRPG and SISR updates
  always_comb begin
    w_state_nxt = r_state;
    w_prpg_nxt  = r_prpg;
    w_sisr_nxt  = r_sisr;
    w_pat_nxt   = r_pat_cnt;
    w_cnt_nxt   = r_shift_cnt;
    w_first_nxt = r_first_load;
`ifdef SCAN_CMP_EN
    w_exp_nxt   = r_exp_sig;
`endif
    w_busy = (r_state == S_SHIFT) || (r_state == S_CAPTURE) || (r_state == S_UNLOAD);
    if (w_busy && bus.i_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            w_pat_nxt   = bus.i_num_patterns;
            w_sisr_nxt  = {LFSR_W{1'b0}};
            w_prpg_nxt  = (bus.i_seed == {LFSR_W{1'b0}}) ? LFSR_W'(1) : bus.i_seed;
            w_first_nxt = 1'b1;
            w_cnt_nxt   = {CNT_W{1'b0}};
`ifdef SCAN_CMP_EN
            w_exp_nxt   = bus.i_expected_sig;
`endif
            w_state_nxt = (bus.i_num_patterns == {PAT_W{1'b0}}) ? S_DONE : S_SHIFT;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_SHIFT: begin
          w_prpg_nxt = lfsr_step(r_prpg, 1'b0);
          // the first load unloads power-up contents, not responses
          if (r_first_load) begin
            w_sisr_nxt = r_sisr;
          end else begin
            w_sisr_nxt = lfsr_step(r_sisr, bus.i_scan_out);
          end
          if (r_shift_cnt == LAST_CNT) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = S_CAPTURE;
          end else begin
            w_cnt_nxt   = r_shift_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          w_pat_nxt   = r_pat_cnt - PAT_W'(1);
          w_first_nxt = 1'b0;
          w_state_nxt = (r_pat_cnt == PAT_W'(1)) ? S_UNLOAD : S_SHIFT;
        end
        S_UNLOAD: begin
          w_sisr_nxt = lfsr_step(r_sisr, bus.i_scan_out);
          if (r_shift_cnt == LAST_CNT) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = r_shift_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPTURE) || (w_state_nxt == S_UNLOAD);
  end

  // State, datapath and registered chain-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prpg       <= LFSR_W'(1);
      r_sisr       <= {LFSR_W{1'b0}};
      r_pat_cnt    <= {PAT_W{1'b0}};
      r_shift_cnt  <= {CNT_W{1'b0}};
      r_first_load <= 1'b0;
      r_se         <= 1'b0;
      r_scan_in    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SCAN_CMP_EN
      r_exp_sig    <= {LFSR_W{1'b0}};
      r_pass       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_prpg       <= w_prpg_nxt;
      r_sisr       <= w_sisr_nxt;
      r_pat_cnt    <= w_pat_nxt;
      r_shift_cnt  <= w_cnt_nxt;
      r_first_load <= w_first_nxt;
      r_se         <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_UNLOAD);
      r_scan_in    <= (w_state_nxt == S_SHIFT) ? w_prpg_nxt[LFSR_W-1] : 1'b0;
      r_busy       <= w_busy_nxt;
      r_done       <= (w_state_nxt == S_DONE);
`ifdef SCAN_CMP_EN
      r_exp_sig    <= w_exp_nxt;
      r_pass       <= (w_state_nxt == S_DONE) && (w_sisr_nxt == w_exp_nxt);
`endif
    end
  end

  assign bus.o_se        = r_se;
  assign bus.o_scan_in   = r_scan_in;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_signature = r_sisr;
`ifdef SCAN_CMP_EN
  assign bus.o_pass      = r_pass;
`endif
endmodule
